ctrl_sequencer_p: RTL and testbench

Parametrised multi-cycle control sequencer for the single-bus CPU. It is the successor to the fixed-timing control unit. It drives the same datapath strobes as one packed control word, and adds:
- a variable-latency memory handshake with timeout
- a configurable MUL/DIV latency
- conditional-branch skip
- synchronous stop/resume and single-step
- illegal-opcode trapping
- retired-instruction counting

It sits between IR/CON FF/memory and the datapath.

---
 rtl/ctrl_sequencer_p.sv | 210 +++++++++++++++++++++
 tb/tb_ctrl_sequencer_p.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer_p.sv
// Multi-cycle control sequencer for the single-bus CPU: one state per datapath step,
// with memory handshake/timeout, MUL/DIV latency, stop/step and retirement counting.
module ctrl_sequencer_p #(
   parameter int OPW         = 5,
   parameter int MULDIV_LAT  = 4,
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [31:0]      IR,
   input  logic             con_ff,
   input  logic             mem_ready,
   input  logic             Stop,
   input  logic             Resume,
   input  logic             step_en,
   output logic [27:0]      ctrl,
   output logic             Run,
   output logic             Clear,
   output logic             illegal_op,
   output logic             bus_error,
   output logic             instr_retired,
   output logic [CNT_W-1:0] instr_count
);

   localparam int PC_OUT = 0,  PC_IN = 1,  INC_PC = 2,  MAR_IN = 3,  MDR_IN = 4,  MDR_READ = 5;
   localparam int MDR_OUT = 6, IR_IN = 7,  Y_IN = 8,    ZH_IN = 9,   ZL_IN = 10,  ZH_OUT = 11;
   localparam int ZL_OUT = 12, HI_IN = 13, LO_IN = 14,  HI_OUT = 15, LO_OUT = 16, GRA = 17;
   localparam int GRB = 18,    GRC = 19,   R_IN = 20,   R_OUT = 21,  BA_OUT = 22, RC_OUT = 23;
   localparam int CON_IN = 24, RAM_WRITE = 25, INPORT_OUT = 26, OUTPORT_IN = 27;

   localparam logic [OPW-1:0] OP_LD   = OPW'(0),  OP_LDI  = OPW'(1),  OP_ST   = OPW'(2);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(3),  OP_SHL  = OPW'(11), OP_ADDI = OPW'(12);
   localparam logic [OPW-1:0] OP_ORI  = OPW'(14), OP_DIV  = OPW'(15), OP_MUL  = OPW'(16);
   localparam logic [OPW-1:0] OP_NEG  = OPW'(17), OP_NOT  = OPW'(18), OP_BR   = OPW'(19);
   localparam logic [OPW-1:0] OP_JAL  = OPW'(20), OP_JR   = OPW'(21), OP_IN   = OPW'(22);
   localparam logic [OPW-1:0] OP_OUT  = OPW'(23), OP_MFLO = OPW'(24), OP_MFHI = OPW'(25);
   localparam logic [OPW-1:0] OP_NOP  = OPW'(26), OP_HALT = OPW'(27);

   typedef enum logic [5:0] {
      S_RST, S_F0, S_F1, S_F2, S_DEC,
      S_A3, S_A4, S_AI4, S_A5, S_U3,
      S_MD3, S_MD4, S_MD5, S_MD6,
      S_LD3, S_LD4, S_LD5, S_LD6, S_LD7, S_ST6, S_ST7,
      S_BR3, S_BR4, S_BR5, S_BR6, S_JR3, S_JAL3, S_JAL4,
      S_MFHI, S_MFLO, S_IN, S_OUT, S_NOP, S_HALT
   } state_t;

   state_t           state_reg, state_next, fetch_next;
   logic             stop_pend_reg;
   logic [4:0]       md_cnt_reg;
   logic [31:0]      wait_cnt_reg;
   logic             illegal_reg, bus_error_reg, retired_reg;
   logic [CNT_W-1:0] count_reg;
   logic             retire_now, illegal_now, bus_err_now;
   logic             mem_timeout, md_last, is_wait;
   logic [OPW-1:0]   op;
   logic             unused_ir;

   assign op        = IR[31 -: OPW];
   assign unused_ir = ^IR[31-OPW:0];
   assign md_last   = (md_cnt_reg == 5'(MULDIV_LAT - 1));
   assign is_wait   = (state_reg == S_F1) || (state_reg == S_LD6) || (state_reg == S_ST7);
   // Counter holds the number of wait cycles already spent without mem_ready.
   assign mem_timeout = (MEM_TIMEOUT != 0) && ((wait_cnt_reg + 32'd1) >= 32'(MEM_TIMEOUT));
   assign fetch_next  = (stop_pend_reg || Stop || step_en) ? S_HALT : S_F0;

   assign Run           = (state_reg != S_HALT);
   assign Clear         = (state_reg == S_RST);
   assign illegal_op    = illegal_reg;
   assign bus_error     = bus_error_reg;
   assign instr_retired = retired_reg;
   assign instr_count   = count_reg;

   always_comb begin
      state_next  = state_reg;
      retire_now  = 1'b0;
      illegal_now = 1'b0;
      bus_err_now = 1'b0;
      unique case (state_reg)
         S_RST:  state_next = S_F0;
         S_F0:   state_next = S_F1;
         S_F1, S_LD6, S_ST7: begin
            if (mem_ready) begin
               if (state_reg == S_F1)       state_next = S_F2;
               else if (state_reg == S_LD6) state_next = S_LD7;
               else begin
                  state_next = fetch_next;
                  retire_now = 1'b1;
               end
            end else if (mem_timeout) begin
               state_next  = S_HALT;
               bus_err_now = 1'b1;
            end
         end
         S_F2:   state_next = S_DEC;
         S_DEC: begin
            if (op == OP_LD || op == OP_LDI || op == OP_ST) state_next = S_LD3;
            else if (op >= OP_ADD && op <= OP_ORI)         state_next = S_A3;
            else if (op == OP_DIV || op == OP_MUL)         state_next = S_MD3;
            else if (op == OP_NEG || op == OP_NOT)         state_next = S_U3;
            else if (op == OP_BR)   state_next = S_BR3;
            else if (op == OP_JAL)  state_next = S_JAL3;
            else if (op == OP_JR)   state_next = S_JR3;
            else if (op == OP_IN)   state_next = S_IN;
            else if (op == OP_OUT)  state_next = S_OUT;
            else if (op == OP_MFLO) state_next = S_MFLO;
            else if (op == OP_MFHI) state_next = S_MFHI;
            else if (op == OP_NOP)  state_next = S_NOP;
            else if (op == OP_HALT) begin
               state_next = S_HALT;
               retire_now = 1'b1;
            end else begin
               state_next  = fetch_next;
               illegal_now = 1'b1;
            end
         end
         S_A3:   state_next = (op >= OP_ADDI) ? S_AI4 : S_A4;
         S_A4, S_AI4, S_U3: state_next = S_A5;
         S_MD3:  state_next = S_MD4;
         S_MD4:  state_next = md_last ? S_MD5 : S_MD4;
         S_MD5:  state_next = S_MD6;
         S_LD3:  state_next = S_LD4;
         S_LD4:  state_next = (op == OP_LDI) ? S_A5 : S_LD5;
         S_LD5:  state_next = (op == OP_ST) ? S_ST6 : S_LD6;
         S_ST6:  state_next = S_ST7;
         S_BR3:  state_next = S_BR4;
         S_BR4: begin
            if (con_ff) state_next = S_BR5;
            else begin
               state_next = fetch_next;
               retire_now = 1'b1;
            end
         end
         S_BR5:  state_next = S_BR6;
         S_JAL3: state_next = S_JAL4;
         S_A5, S_MD6, S_LD7, S_BR6, S_JR3, S_JAL4, S_MFHI, S_MFLO, S_IN, S_OUT, S_NOP: begin
            state_next = fetch_next;
            retire_now = 1'b1;
         end
         S_HALT: if (Resume) state_next = S_F0;
         default: state_next = S_RST;
      endcase
   end

   always_comb begin
      ctrl = '0;
      unique case (state_reg)
         S_F0:   begin ctrl[PC_OUT] = 1'b1; ctrl[MAR_IN] = 1'b1; end
         S_F1, S_LD6: begin ctrl[MDR_READ] = 1'b1; ctrl[MDR_IN] = 1'b1; end
         S_F2:   begin ctrl[MDR_OUT] = 1'b1; ctrl[IR_IN] = 1'b1; ctrl[INC_PC] = 1'b1; end
         S_A3, S_MD3: begin ctrl[GRB] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[Y_IN] = 1'b1; end
         S_A4:   begin ctrl[GRC] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[ZH_IN] = 1'b1; ctrl[ZL_IN] = 1'b1; end
         S_AI4, S_LD4, S_BR5: begin ctrl[RC_OUT] = 1'b1; ctrl[ZH_IN] = 1'b1; ctrl[ZL_IN] = 1'b1; end
         S_U3:   begin ctrl[GRB] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[ZH_IN] = 1'b1; ctrl[ZL_IN] = 1'b1; end
         S_A5:   begin ctrl[ZL_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; end
         S_MD4: begin
            ctrl[GRA]   = 1'b1;
            ctrl[R_OUT] = 1'b1;
            ctrl[ZH_IN] = md_last;
            ctrl[ZL_IN] = md_last;
         end
         S_MD5:  begin ctrl[ZL_OUT] = 1'b1; ctrl[LO_IN] = 1'b1; end
         S_MD6:  begin ctrl[ZH_OUT] = 1'b1; ctrl[HI_IN] = 1'b1; end
         S_LD3:  begin ctrl[GRB] = 1'b1; ctrl[BA_OUT] = 1'b1; ctrl[Y_IN] = 1'b1; end
         S_LD5:  begin ctrl[ZL_OUT] = 1'b1; ctrl[MAR_IN] = 1'b1; end
         S_LD7:  begin ctrl[MDR_OUT] = 1'b1; ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; end
         S_ST6:  begin ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[MDR_IN] = 1'b1; end
         S_ST7:  ctrl[RAM_WRITE] = 1'b1;
         S_BR3:  begin ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[CON_IN] = 1'b1; end
         S_BR4:  begin ctrl[PC_OUT] = 1'b1; ctrl[Y_IN] = 1'b1; end
         S_BR6:  begin ctrl[ZL_OUT] = 1'b1; ctrl[PC_IN] = 1'b1; end
         S_JR3, S_JAL4: begin ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[PC_IN] = 1'b1; end
         S_JAL3: begin ctrl[PC_OUT] = 1'b1; ctrl[GRB] = 1'b1; ctrl[R_IN] = 1'b1; end
         S_MFHI: begin ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; ctrl[HI_OUT] = 1'b1; end
         S_MFLO: begin ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; ctrl[LO_OUT] = 1'b1; end
         S_IN:   begin ctrl[GRA] = 1'b1; ctrl[R_IN] = 1'b1; ctrl[INPORT_OUT] = 1'b1; end
         S_OUT:  begin ctrl[GRA] = 1'b1; ctrl[R_OUT] = 1'b1; ctrl[OUTPORT_IN] = 1'b1; end
         default: ctrl = '0;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_reg     <= S_RST;
         stop_pend_reg <= 1'b0;
         md_cnt_reg    <= '0;
         wait_cnt_reg  <= '0;
         illegal_reg   <= 1'b0;
         bus_error_reg <= 1'b0;
         retired_reg   <= 1'b0;
         count_reg     <= '0;
      end else begin
         state_reg <= state_next;
         // Stop is ignored while halted, so Resume always wins a tie.
         if (state_reg == S_HALT) begin
            if (Resume) stop_pend_reg <= 1'b0;
         end else if (Stop) begin
            stop_pend_reg <= 1'b1;
         end
         md_cnt_reg   <= (state_reg == S_MD4 && state_next == S_MD4) ? md_cnt_reg + 5'd1 : '0;
         wait_cnt_reg <= (is_wait && state_next == state_reg) ? wait_cnt_reg + 32'd1 : '0;
         illegal_reg   <= illegal_now;
         bus_error_reg <= bus_err_now;
         retired_reg   <= retire_now;
         if (retire_now) count_reg <= count_reg + 1'b1;
      end
   end

endmodule

// File: tb/tb_ctrl_sequencer_p.sv
// Directed bench for ctrl_sequencer_p: table of instruction strobe sequences plus
// hand-written wait, timeout, stop/step, illegal-opcode and reset sequences.
module tb_ctrl_sequencer_p;

   localparam logic [27:0] PCOUT = 28'h1 << 0,  PCIN = 28'h1 << 1,  INCPC = 28'h1 << 2;
   localparam logic [27:0] MARIN = 28'h1 << 3,  MDRIN = 28'h1 << 4, MDRRD = 28'h1 << 5;
   localparam logic [27:0] MDROUT = 28'h1 << 6, IRIN = 28'h1 << 7,  YIN = 28'h1 << 8;
   localparam logic [27:0] ZHIN = 28'h1 << 9,   ZLIN = 28'h1 << 10, ZHOUT = 28'h1 << 11;
   localparam logic [27:0] ZLOUT = 28'h1 << 12, HIIN = 28'h1 << 13, LOIN = 28'h1 << 14;
   localparam logic [27:0] HIOUT = 28'h1 << 15, LOOUT = 28'h1 << 16, GRA = 28'h1 << 17;
   localparam logic [27:0] GRB = 28'h1 << 18,   GRC = 28'h1 << 19,  RIN = 28'h1 << 20;
   localparam logic [27:0] ROUT = 28'h1 << 21,  BAOUT = 28'h1 << 22, RCOUT = 28'h1 << 23;
   localparam logic [27:0] CONIN = 28'h1 << 24, RAMWR = 28'h1 << 25, INPOUT = 28'h1 << 26;
   localparam logic [27:0] OUTPIN = 28'h1 << 27;
   localparam logic [27:0] ST_F0 = PCOUT | MARIN, ST_F1 = MDRRD | MDRIN;
   localparam logic [27:0] ST_F2 = MDROUT | IRIN | INCPC;

   logic        Clock = 1'b0, Reset = 1'b1;
   logic [31:0] IR = '0;
   logic        con_ff = 1'b0, mem_ready = 1'b1, Stop = 1'b0, Resume = 1'b0, step_en = 1'b0;
   logic [27:0] ctrl, t_ctrl;
   logic        run, clear, illegal_op, bus_error, retired;
   logic        t_run, t_clear, t_illegal, t_bus_error, t_retired;
   logic [31:0] count;
   logic [1:0]  t_count;

   ctrl_sequencer_p #(.OPW(5), .MULDIV_LAT(4), .MEM_TIMEOUT(0), .CNT_W(32)) dut (
      .Clock(Clock), .Reset(Reset), .IR(IR), .con_ff(con_ff), .mem_ready(mem_ready),
      .Stop(Stop), .Resume(Resume), .step_en(step_en), .ctrl(ctrl), .Run(run), .Clear(clear),
      .illegal_op(illegal_op), .bus_error(bus_error), .instr_retired(retired),
      .instr_count(count));

   ctrl_sequencer_p #(.OPW(5), .MULDIV_LAT(4), .MEM_TIMEOUT(2), .CNT_W(2)) dut_to (
      .Clock(Clock), .Reset(Reset), .IR(IR), .con_ff(con_ff), .mem_ready(mem_ready),
      .Stop(Stop), .Resume(Resume), .step_en(step_en), .ctrl(t_ctrl), .Run(t_run),
      .Clear(t_clear), .illegal_op(t_illegal), .bus_error(t_bus_error),
      .instr_retired(t_retired), .instr_count(t_count));

   always #5 Clock = ~Clock;

   typedef struct {
      logic [4:0]        op;
      logic              con;
      int                len;
      logic [10:0][27:0] seq;
   } vec_t;

   vec_t vecs [0:23];
   int   nv = 0;
   int   passed = 0, total = 0;
   int   exp_count = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic step(input string name, input logic [27:0] exp);
      check(name, {36'd0, ctrl}, {36'd0, exp});
      @(negedge Clock);
   endtask

   task automatic add(input logic [4:0] op, input logic con, input int n,
                      input logic [27:0] e0, e1, e2, e3, e4, e5, e6);
      vecs[nv].op  = op;
      vecs[nv].con = con;
      vecs[nv].len = 4 + n;
      vecs[nv].seq = '0;
      vecs[nv].seq[0] = ST_F0;  vecs[nv].seq[1] = ST_F1;  vecs[nv].seq[2] = ST_F2;
      vecs[nv].seq[3] = '0;
      vecs[nv].seq[4] = e0;  vecs[nv].seq[5] = e1;  vecs[nv].seq[6] = e2;
      vecs[nv].seq[7] = e3;  vecs[nv].seq[8] = e4;  vecs[nv].seq[9] = e5;
      vecs[nv].seq[10] = e6;
      nv++;
   endtask

   task automatic do_reset();
      Reset = 1'b1; mem_ready = 1'b1; Stop = 1'b0; Resume = 1'b0; step_en = 1'b0;
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      exp_count = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      add(5'd0,  1'b0, 5, GRB|BAOUT|YIN, RCOUT|ZHIN|ZLIN, ZLOUT|MARIN, MDRRD|MDRIN, MDROUT|GRA|RIN, 0, 0);
      add(5'd1,  1'b0, 3, GRB|BAOUT|YIN, RCOUT|ZHIN|ZLIN, ZLOUT|GRA|RIN, 0, 0, 0, 0);
      add(5'd2,  1'b0, 5, GRB|BAOUT|YIN, RCOUT|ZHIN|ZLIN, ZLOUT|MARIN, GRA|ROUT|MDRIN, RAMWR, 0, 0);
      add(5'd3,  1'b0, 3, GRB|ROUT|YIN, GRC|ROUT|ZHIN|ZLIN, ZLOUT|GRA|RIN, 0, 0, 0, 0);
      add(5'd11, 1'b0, 3, GRB|ROUT|YIN, GRC|ROUT|ZHIN|ZLIN, ZLOUT|GRA|RIN, 0, 0, 0, 0);
      add(5'd12, 1'b0, 3, GRB|ROUT|YIN, RCOUT|ZHIN|ZLIN, ZLOUT|GRA|RIN, 0, 0, 0, 0);
      add(5'd14, 1'b0, 3, GRB|ROUT|YIN, RCOUT|ZHIN|ZLIN, ZLOUT|GRA|RIN, 0, 0, 0, 0);
      add(5'd17, 1'b0, 2, GRB|ROUT|ZHIN|ZLIN, ZLOUT|GRA|RIN, 0, 0, 0, 0, 0);
      add(5'd16, 1'b0, 7, GRB|ROUT|YIN, GRA|ROUT, GRA|ROUT, GRA|ROUT, GRA|ROUT|ZHIN|ZLIN,
          ZLOUT|LOIN, ZHOUT|HIIN);
      add(5'd15, 1'b0, 7, GRB|ROUT|YIN, GRA|ROUT, GRA|ROUT, GRA|ROUT, GRA|ROUT|ZHIN|ZLIN,
          ZLOUT|LOIN, ZHOUT|HIIN);
      add(5'd19, 1'b0, 2, GRA|ROUT|CONIN, PCOUT|YIN, 0, 0, 0, 0, 0);
      add(5'd19, 1'b1, 4, GRA|ROUT|CONIN, PCOUT|YIN, RCOUT|ZHIN|ZLIN, ZLOUT|PCIN, 0, 0, 0);
      add(5'd20, 1'b0, 2, PCOUT|GRB|RIN, GRA|ROUT|PCIN, 0, 0, 0, 0, 0);
      add(5'd21, 1'b0, 1, GRA|ROUT|PCIN, 0, 0, 0, 0, 0, 0);
      add(5'd22, 1'b0, 1, GRA|RIN|INPOUT, 0, 0, 0, 0, 0, 0);
      add(5'd23, 1'b0, 1, GRA|ROUT|OUTPIN, 0, 0, 0, 0, 0, 0);
      add(5'd24, 1'b0, 1, GRA|RIN|LOOUT, 0, 0, 0, 0, 0, 0);
      add(5'd25, 1'b0, 1, GRA|RIN|HIOUT, 0, 0, 0, 0, 0, 0);
      add(5'd26, 1'b0, 1, 28'h0, 0, 0, 0, 0, 0, 0);

      // Reset state
      @(negedge Clock);
      check("rst_ctrl", {36'd0, ctrl}, 64'd0);
      check("rst_clear", {63'd0, clear}, 64'd1);
      check("rst_run", {63'd0, run}, 64'd1);
      check("rst_count", {32'd0, count}, 64'd0);
      check("rst_pulses", {61'd0, retired, illegal_op, bus_error}, 64'd0);
      Reset = 1'b0;
      @(negedge Clock);
      check("first_f0_clear", {63'd0, clear}, 64'd0);

      // Table of instructions, memory always ready
      for (int i = 0; i < nv; i++) begin
         IR     = {vecs[i].op, 27'h0123456};
         con_ff = vecs[i].con;
         for (int k = 0; k < vecs[i].len; k++)
            step($sformatf("v%0d_op%0d_step%0d", i, vecs[i].op, k), vecs[i].seq[k]);
         exp_count++;
         check($sformatf("v%0d_retired", i), {63'd0, retired}, 64'd1);
         check($sformatf("v%0d_count", i), {32'd0, count}, 64'(exp_count));
         check($sformatf("v%0d_back_to_f0", i), {36'd0, ctrl}, {36'd0, ST_F0});
         $display("vec %0d op=%0d con=%0d cycles=%0d count=%0d", i, vecs[i].op, vecs[i].con,
                  vecs[i].len, count);
      end
      check("wrap_count_cntw2", {62'd0, t_count}, 64'(exp_count % 4));

      // ld with memory waits in fetch and in the data read
      IR = 32'h0000_0000; mem_ready = 1'b0;
      step("ldw_f0", ST_F0);
      step("ldw_f1_a", ST_F1); step("ldw_f1_b", ST_F1); step("ldw_f1_c", ST_F1);
      mem_ready = 1'b1;
      step("ldw_f1_d", ST_F1); step("ldw_f2", ST_F2); step("ldw_dec", 28'h0);
      step("ldw_ld3", GRB|BAOUT|YIN); step("ldw_ld4", RCOUT|ZHIN|ZLIN);
      mem_ready = 1'b0;
      step("ldw_ld5", ZLOUT|MARIN);
      step("ldw_rd_a", MDRRD|MDRIN); step("ldw_rd_b", MDRRD|MDRIN);
      mem_ready = 1'b1;
      step("ldw_rd_c", MDRRD|MDRIN); step("ldw_ld7", MDROUT|GRA|RIN);
      exp_count++;
      check("ldw_count", {32'd0, count}, 64'(exp_count));
      $display("ld with waits done, count=%0d", count);

      // Timeout on the MEM_TIMEOUT=2 instance
      do_reset();
      IR = 32'h0000_0000; mem_ready = 1'b0;
      repeat (3) @(negedge Clock);
      check("to_run", {63'd0, t_run}, 64'd0);
      check("to_bus_error", {63'd0, t_bus_error}, 64'd1);
      check("to_ctrl", {36'd0, t_ctrl}, 64'd0);
      check("to_count", {62'd0, t_count}, 64'd0);
      check("to_retired", {63'd0, t_retired}, 64'd0);
      @(negedge Clock);
      check("to_bus_error_pulse", {63'd0, t_bus_error}, 64'd0);
      check("to_still_halt", {63'd0, t_run}, 64'd0);
      $display("timeout sequence done");

      // Stop during st, then Stop+Resume together
      do_reset();
      IR = {5'd2, 27'h0};
      step("st_f0", ST_F0); step("st_f1", ST_F1); step("st_f2", ST_F2); step("st_dec", 28'h0);
      Stop = 1'b1;
      step("st_ld3", GRB|BAOUT|YIN);
      Stop = 1'b0;
      step("st_ld4", RCOUT|ZHIN|ZLIN); step("st_ld5", ZLOUT|MARIN);
      step("st_st6", GRA|ROUT|MDRIN); step("st_st7", RAMWR);
      check("st_halt_ctrl", {36'd0, ctrl}, 64'd0);
      check("st_halt_run", {63'd0, run}, 64'd0);
      check("st_retired", {63'd0, retired}, 64'd1);
      check("st_count", {32'd0, count}, 64'd1);
      @(negedge Clock);
      check("st_halt_hold", {63'd0, run}, 64'd0);
      Stop = 1'b1; Resume = 1'b1;
      @(negedge Clock);
      Stop = 1'b0; Resume = 1'b0;
      check("resume_f0", {36'd0, ctrl}, {36'd0, ST_F0});
      check("resume_run", {63'd0, run}, 64'd1);
      IR = {5'd26, 27'h0};
      step("nop_f0", ST_F0); step("nop_f1", ST_F1); step("nop_f2", ST_F2);
      step("nop_dec", 28'h0); step("nop_ex", 28'h0);
      check("no_stale_stop", {36'd0, ctrl}, {36'd0, ST_F0});
      check("nop_count", {32'd0, count}, 64'd2);
      $display("stop/resume sequence done, count=%0d", count);

      // Single-step, then halt opcode
      step_en = 1'b1;
      repeat (5) @(negedge Clock);
      check("step_halt_run", {63'd0, run}, 64'd0);
      check("step_count", {32'd0, count}, 64'd3);
      Resume = 1'b1;
      @(negedge Clock);
      Resume = 1'b0;
      check("step_resume_f0", {36'd0, ctrl}, {36'd0, ST_F0});
      IR = {5'd27, 27'h0};
      repeat (4) @(negedge Clock);
      check("haltop_run", {63'd0, run}, 64'd0);
      check("haltop_retired", {63'd0, retired}, 64'd1);
      check("haltop_count", {32'd0, count}, 64'd4);
      step_en = 1'b0; Resume = 1'b1;
      @(negedge Clock);
      Resume = 1'b0;
      $display("single-step and halt opcode done, count=%0d", count);

      // Illegal opcode
      IR = {5'b11111, 27'h0};
      step("ill_f0", ST_F0); step("ill_f1", ST_F1); step("ill_f2", ST_F2); step("ill_dec", 28'h0);
      check("ill_pulse", {63'd0, illegal_op}, 64'd1);
      check("ill_no_retire", {63'd0, retired}, 64'd0);
      check("ill_count", {32'd0, count}, 64'd4);
      check("ill_f0_again", {36'd0, ctrl}, {36'd0, ST_F0});
      @(negedge Clock);
      check("ill_pulse_end", {63'd0, illegal_op}, 64'd0);
      $display("illegal opcode done");

      // Reset mid-ld acts immediately
      IR = 32'h0000_0000;
      step("rld_f1", ST_F1); step("rld_f2", ST_F2); step("rld_dec", 28'h0);
      step("rld_ld3", GRB|BAOUT|YIN);
      check("rld_ld4", {36'd0, ctrl}, {36'd0, RCOUT|ZHIN|ZLIN});
      Reset = 1'b1;
      #1;
      check("rld_ctrl", {36'd0, ctrl}, 64'd0);
      check("rld_clear", {63'd0, clear}, 64'd1);
      check("rld_count", {32'd0, count}, 64'd0);
      @(negedge Clock);
      Reset = 1'b0;
      $display("reset mid-ld done");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
